alu_dadd_seq: RTL and testbench
===============================

# alu_dadd_seq

Parametrised, digit-serial packed-BCD adder/subtractor for the XM23 execute stage, replacing the single-cycle 16-bit decimal add path. It accepts one operation through a valid/ready handshake and processes `DPC` BCD digits per cycle over a `DIGITS`-digit word. It supports word and byte modes and returns the result together with PSW flag values and a PSW update mask. All operands are registered at accept, so upstream may change inputs immediately afterwards.

## Interface
- `DIGITS`, 4, BCD digits per word; must be even and ≥2.
- `DPC`, 1, digits processed per cycle; `DIGITS % DPC == 0`, else `$error` at elaboration.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept.
- `a`, `b`  in  4·DIGITS  packed BCD operands.
- `carry_in`  in  1  decimal carry-in (PSW.C).
- `sub`  in  1  1 = subtract (a − b), 0 = add.
- `byte_mode`  in  1  operate on low DIGITS/2 digits only.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  4·DIGITS  packed BCD result.
- `psw_out`  out  16  flag values: bit0 C, bit1 Z, bit2 N, bit4 V; all other bits 0.
- `psw_msk`  out  16  flags to update: 16'h0003 (C, Z).
- `err`  out  1  an operand digit > 9 was present at accept.

## Operation
- Handshake:
  - Accept when `in_valid && in_ready`.
  - `in_ready` = (state == IDLE).
  - Result transfers when `out_valid && out_ready`.
  - Outputs are held stable while `out_valid && !out_ready`.
- FSM:
  - IDLE → RUN on accept; `digit_idx` ← 0; `carry` ← `carry_in`; operands latched.
  - RUN processes digits `digit_idx .. digit_idx+DPC−1`, then advances `digit_idx` by DPC.
  - RUN → DONE after the last active group. The active count is DIGITS, or DIGITS/2 in byte mode.
  - DONE → IDLE on `out_ready`.
- Per-digit arithmetic:
  - `bd` = `sub` ? 9 − b_digit : b_digit.
  - `s` = a_digit + bd + carry, computed 5 bits wide.
  - If `s` > 9: digit = (s + 6)[3:0], carry = 1. Otherwise digit = s[3:0], carry = 0.
  - The carry chains across digits within a cycle and across cycles.
- Subtract is nines-complement. With `carry_in`=1 it yields a − b, and C=1 means no borrow.
- Byte mode:
  - Upper DIGITS/2 result digits = the upper digits of `a`, passed through.
  - C = carry out of digit DIGITS/2−1.
  - Z covers the low half only.
- Flags:
  - C = final carry.
  - Z = 1 iff all active result digits are 0.
  - N = 0 and V = 0 always; neither is masked.
- `err` is set at accept if any digit of `a` or `b` in the active range is > 9. The result is still computed by the rule above. `err` clears at the next accept.

## Timing
- Reset (async assert): state IDLE; `in_ready`=1; `out_valid`=0; `result`, `psw_out`, `err`, and the internal carry/index all 0. `psw_msk` is constant.
- Reset asserted mid-RUN or in DONE aborts the operation; no result is produced.
- Latency: accept on edge E0, RUN occupies K = active_digits/DPC cycles, and `out_valid` rises after edge E0+K.
  - Defaults, word mode: K = 4.
  - Defaults, byte mode: K = 2.
- Throughput: one operation per K+2 cycles (the return through IDLE costs one cycle). `in_ready` is low from E0 until the edge after the output handshake.
- `result` digits update in place during RUN, but are only valid while `out_valid`=1.

## Configuration
- `ALU_DADD_SUB_EN` defined: the `sub` input behaves as specified above.
- `ALU_DADD_SUB_EN` undefined:
  - The complement logic is removed and `sub` is ignored (treated as 0).
  - A bench driving `sub`=1 gets an addition.

## Structure
- Shared package `alu_pkg`:
  - PSW bit index constants `PSW_C`, `PSW_Z`, `PSW_N`, `PSW_V`.
  - `typedef logic [3:0] bcd_digit_t`.
  - FSM state enum `dadd_state_t {IDLE, RUN, DONE}`.
- Sub-module `bcd_digit_add`: combinational single-digit add with carry in/out plus complement select. Instantiated DPC times in a generate loop.

## Test plan
- Add, word: a=0x1234, b=0x8766, cin=0 → result=0x0000, C=1, Z=1, err=0; `out_valid` exactly 4 cycles after accept.
- Max digit sum: a=0x0009, b=0x0009, cin=1 → result=0x0019, C=0, Z=0. This checks the 5-bit sum (19).
- Subtract: a=0x0500, b=0x0123, cin=1, sub=1 → result=0x0377, C=1. Swapping operands → result=0x9623, C=0.
- Byte mode: a=0xAB55, b=0x0047, cin=0 → result=0xAB02, C=1, Z=0, err=0, K=2. Upper digits A/B are not checked.
- Backpressure, then reset: hold `out_ready`=0 for 5 cycles → `result`/flags stable and `in_ready`=0. Assert `rst_n`=0 mid-RUN of the next operation → `out_valid`=0 immediately, IDLE after release.
- Invalid digit: a=0x000A, b=0x0001 → err=1, result=0x0011, C=0. With DPC=2 and DIGITS=8, random BCD vectors match a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the XM23 decimal adder slice.
// PSW bit positions, BCD digit type and adder FSM states.
package alu_pkg;

  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dadd_state_t;

endpackage

// File: rtl/alu_dadd_seq_if.sv
// Operation/result handshake bundle for alu_dadd_seq.
// master drives operands and out_ready; slave is the adder.
interface alu_dadd_seq_if #(
  parameter int DIGITS = 4
) ();
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                carry_in;
  logic                sub;
  logic                byte_mode;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] result;
  logic [15:0]         psw_out;
  logic [15:0]         psw_msk;
  logic                err;

  modport master (
    output in_valid, a, b, carry_in, sub,
    output byte_mode, out_ready,
    input  in_ready, out_valid, result,
    input  psw_out, psw_msk, err
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub,
    input  byte_mode, out_ready,
    output in_ready, out_valid, result,
    output psw_out, psw_msk, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry and nines-complement of b.
// Complement logic exists only with ALU_DADD_SUB_EN defined.
module bcd_digit_add
  import alu_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       sub,
  input  logic       ci,
  output bcd_digit_t sum,
  output logic       co
);

  bcd_digit_t bd;
  logic [4:0] s;

  // 5-bit binary sum, decimal-adjusted when above 9
  always_comb begin
`ifdef ALU_DADD_SUB_EN
    bd = sub ? (4'd9 - b) : b;
`else
    bd = b;
`endif
    s = {1'b0, a} + {1'b0, bd} + {4'd0, ci};
    if (s > 5'd9) begin
      sum = 4'(s + 5'd6);
      co  = 1'b1;
    end else begin
      sum = s[3:0];
      co  = 1'b0;
    end
  end

`ifndef ALU_DADD_SUB_EN
  logic unused_sub;
  assign unused_sub = sub;
`endif

endmodule

// File: rtl/alu_dadd_seq.sv
// Digit-serial packed-BCD add/sub, DPC digits per cycle.
// Optional subtract path: ALU_DADD_SUB_EN.
module alu_dadd_seq
  import alu_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DPC    = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_dadd_seq_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);

  if ((DIGITS % DPC) != 0) begin : g_bad_dpc
    $error("DIGITS must be a multiple of DPC");
  end
  if ((DIGITS % 2) != 0 || DIGITS < 2) begin : g_bad_dig
    $error("DIGITS must be even and >= 2");
  end

  dadd_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            byte_q, byte_d;
  logic            sub_q, sub_d;
  logic            err_q, err_d;
  logic [15:0]     psw_q, psw_d;

  logic            rdy;
  logic            accept;
  logic            last;
  logic            bad_in;
  logic [IW-1:0]   act;
  logic [IW-1:0]   act_in;
  logic [DPC-1:0]  en;
  logic [4*DPC-1:0] ga, gb, gs;
  logic            carry_out;

  assign rdy    = (state_q == IDLE);
  assign accept = bus.in_valid && rdy;
  assign act    = byte_q ? IW'(DIGITS / 2) : IW'(DIGITS);
  assign act_in = bus.byte_mode ? IW'(DIGITS / 2)
                                : IW'(DIGITS);
  assign last   = (int'(idx_q) + DPC) >= int'(act);

`ifdef ALU_DADD_SUB_EN
  assign sub_d = accept ? bus.sub : sub_q;
`else
  assign sub_d = 1'b0;
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)        state_d = RUN;
      RUN:  if (last)          state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = rdy;
    bus.out_valid = (state_q == DONE);
  end

  // select the digit group for this cycle
  always_comb begin
    en = '0;
    ga = '0;
    gb = '0;
    for (int g = 0; g < DPC; g++) begin
      if (int'(idx_q) + g < int'(act)) begin
        en[g]        = 1'b1;
        ga[g*4 +: 4] = a_q[(int'(idx_q) + g)*4 +: 4];
        gb[g*4 +: 4] = b_q[(int'(idx_q) + g)*4 +: 4];
      end
    end
  end

  for (genvar g = 0; g < DPC; g++) begin : g_dig
    logic       ci;
    logic       co;
    logic       cn;
    bcd_digit_t sum;
    if (g == 0) begin : g_first
      assign ci = carry_q;
    end else begin : g_next
      assign ci = g_dig[g-1].cn;
    end
    bcd_digit_add u_add (
      .a   (ga[g*4 +: 4]),
      .b   (gb[g*4 +: 4]),
      .sub (sub_q),
      .ci  (ci),
      .sum (sum),
      .co  (co)
    );
    assign cn = en[g] ? co : ci;
    assign gs[g*4 +: 4] = sum;
  end

  assign carry_out = g_dig[DPC-1].cn;

  // any non-BCD digit in the active range of the offer
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < int'(act_in)) begin
        if (bus.a[i*4 +: 4] > 4'd9) bad_in = 1'b1;
        if (bus.b[i*4 +: 4] > 4'd9) bad_in = 1'b1;
      end
    end
  end

  // datapath: latch at accept, fold digits in RUN
  always_comb begin
    logic nz;
    a_d     = a_q;
    b_d     = b_q;
    byte_d  = byte_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    err_d   = err_q;
    psw_d   = psw_q;
    nz      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          byte_d  = bus.byte_mode;
          carry_d = bus.carry_in;
          idx_d   = '0;
          res_d   = bus.a;
          err_d   = bad_in;
        end
      end
      RUN: begin
        for (int g = 0; g < DPC; g++) begin
          if (en[g])
            res_d[(int'(idx_q) + g)*4 +: 4] =
              gs[g*4 +: 4];
        end
        carry_d = carry_out;
        idx_d   = idx_q + IW'(DPC);
        if (last) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(act) && res_d[i*4 +: 4] != 4'd0)
              nz = 1'b1;
          end
          psw_d        = '0;
          psw_d[PSW_C] = carry_out;
          psw_d[PSW_Z] = ~nz;
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      byte_q  <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      psw_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      byte_q  <= byte_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
      psw_q   <= psw_d;
    end
  end

  assign bus.result  = res_q;
  assign bus.psw_out = psw_q;
  assign bus.psw_msk = 16'h0003;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_alu_dadd_seq.sv
// Directed bench for alu_dadd_seq: 4-digit DPC=1 and
// 8-digit DPC=2 instances, hand-computed vectors.
module tb_alu_dadd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  alu_dadd_seq_if #(.DIGITS(4)) bus0 ();
  alu_dadd_seq_if #(.DIGITS(8)) bus1 ();

  alu_dadd_seq #(.DIGITS(4), .DPC(1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  alu_dadd_seq #(.DIGITS(8), .DPC(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic op0(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic cin, input logic sb,
                     input logic bm,
                     input logic [15:0] er,
                     input logic [15:0] ep,
                     input logic ee, input int ek);
    int n;
    logic [15:0] m;
    m = bm ? 16'h00FF : 16'hFFFF;
    bus0.a = a; bus0.b = b;
    bus0.carry_in = cin; bus0.sub = sb;
    bus0.byte_mode = bm; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.a = 16'hFFFF; bus0.b = 16'hFFFF;
    bus0.carry_in = ~cin; bus0.byte_mode = ~bm;
    chk({tag, "_busy"}, 32'(bus0.in_ready), 32'd0);
    n = 0;
    while (!bus0.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, ek);
    chk({tag, "_res"}, 32'(bus0.result & m), 32'(er & m));
    chk({tag, "_psw"}, 32'(bus0.psw_out), 32'(ep));
    chk({tag, "_err"}, 32'(bus0.err), 32'(ee));
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(bus0.in_ready), 32'd1);
  endtask

  task automatic op1(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic cin, input logic bm,
                     input logic [31:0] er,
                     input logic [15:0] ep, input int ek);
    int n;
    bus1.a = a; bus1.b = b;
    bus1.carry_in = cin; bus1.sub = 1'b0;
    bus1.byte_mode = bm; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.a = '0; bus1.b = '0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, ek);
    chk({tag, "_res"}, bus1.result, er);
    chk({tag, "_psw"}, 32'(bus1.psw_out), 32'(ep));
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus0.a = '0; bus0.b = '0; bus0.carry_in = 1'b0;
    bus0.sub = 1'b0; bus0.byte_mode = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
    bus1.sub = 1'b0; bus1.byte_mode = 1'b0;

    #12;
    chk("rst_rdy", 32'(bus0.in_ready), 32'd1);
    chk("rst_ov", 32'(bus0.out_valid), 32'd0);
    chk("rst_res", 32'(bus0.result), 32'd0);
    chk("rst_psw", 32'(bus0.psw_out), 32'd0);
    chk("rst_err", 32'(bus0.err), 32'd0);
    chk("rst_msk", 32'(bus0.psw_msk), 32'h3);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    op0("add", 16'h1234, 16'h8766, 0, 0, 0,
        16'h0000, 16'h0003, 0, 4);
    op0("max", 16'h0009, 16'h0009, 1, 0, 0,
        16'h0019, 16'h0000, 0, 4);
`ifdef ALU_DADD_SUB_EN
    op0("sub", 16'h0500, 16'h0123, 1, 1, 0,
        16'h0377, 16'h0001, 0, 4);
    op0("subsw", 16'h0123, 16'h0500, 1, 1, 0,
        16'h9623, 16'h0000, 0, 4);
`else
    op0("sub", 16'h0500, 16'h0123, 1, 1, 0,
        16'h0624, 16'h0000, 0, 4);
    op0("subsw", 16'h0123, 16'h0500, 1, 1, 0,
        16'h0624, 16'h0000, 0, 4);
`endif
    op0("byte", 16'hAB55, 16'h0047, 0, 0, 1,
        16'hAB02, 16'h0001, 0, 2);
    op0("inv", 16'h000A, 16'h0001, 0, 0, 0,
        16'h0011, 16'h0000, 1, 4);
    op0("errclr", 16'h0001, 16'h0002, 0, 0, 0,
        16'h0003, 16'h0000, 0, 4);

    op1("w8a", 32'h12345678, 32'h87654321, 0, 0,
        32'h99999999, 16'h0000, 4);
    op1("w8b", 32'h99999999, 32'h00000001, 0, 0,
        32'h00000000, 16'h0003, 4);
    op1("w8c", 32'h49999999, 32'h50000000, 1, 0,
        32'h00000000, 16'h0003, 4);
    op1("b8", 32'h12349999, 32'h00000001, 0, 1,
        32'h12340000, 16'h0003, 2);

    // backpressure: hold out_ready low for 5 cycles
    bus0.a = 16'h1111; bus0.b = 16'h2222;
    bus0.carry_in = 1'b0; bus0.sub = 1'b0;
    bus0.byte_mode = 1'b0; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", 32'(bus0.result), 32'h3333);
      chk("bp_psw", 32'(bus0.psw_out), 32'h0);
      chk("bp_rdy", 32'(bus0.in_ready), 32'd0);
      chk("bp_ov", 32'(bus0.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    chk("bp_idle", 32'(bus0.in_ready), 32'd1);

    // reset in the middle of RUN
    bus0.a = 16'h0001; bus0.b = 16'h0001;
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(bus0.out_valid), 32'd0);
    chk("ar_rdy", 32'(bus0.in_ready), 32'd1);
    chk("ar_res", 32'(bus0.result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle", 32'(bus0.in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus0.out_valid) n++;
      @(posedge clk); #1;
    end
    chk("ar_nores", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
